// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared FIFO definitions: arbiter state encoding, FIFO sizing constants and
// the FIFO controller state encodings used by the other FIFO blocks.
package fifo_pkg;

  localparam int DEPTH = 8;
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT0  = 2'd1,
    GNT1  = 2'd2,
    STALL = 2'd3
  } arb_state_t;

  typedef enum logic [2:0] {
    INIT     = 3'd0,
    WRITE    = 3'd1,
    READ     = 3'd2,
    WR_ERROR = 3'd3,
    RD_ERROR = 3'd4
  } fifo_state_t;

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Producer/consumer handshake bundle between the producers, the write arbiter
// and the FIFO write side.
interface fifo_wr_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 4
) ();

  logic              req0;
  logic [DATA_W-1:0] din0;
  logic              ack0;
  logic              req1;
  logic [DATA_W-1:0] din1;
  logic              ack1;
  logic              rd_done;
  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic [CNT_W-1:0]  credits;
  logic              stall;
  logic              rd_err;

  modport slave (
    input  req0, din0, req1, din1, rd_done,
    output ack0, ack1, wr_en, wr_data, credits, stall, rd_err
  );

  modport master (
    output req0, din0, req1, din1, rd_done,
    input  ack0, ack1, wr_en, wr_data, credits, stall, rd_err
  );

endinterface

// File: rtl/fifo_credit_cnt.sv
// Free-slot counter for the FIFO: +1 per completed read, -1 per write grant,
// saturating at 0 and DEPTH; a read report while already full flags rd_err.
module fifo_credit_cnt #(
  parameter int DEPTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             dec,
  input  logic             inc,
  output logic [CNT_W-1:0] credits,
  output logic             zero,
  output logic             rd_err
);

  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  logic [CNT_W-1:0] r_credits;
  logic             r_rd_err;
  logic             w_full;
  logic             w_zero;
  logic             w_inc_ok;
  logic             w_dec_ok;

  assign w_full   = (r_credits == FULL);
  assign w_zero   = (r_credits == '0);
  assign w_inc_ok = inc & ~w_full;
  assign w_dec_ok = dec & ~w_zero;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      r_credits <= FULL;
      r_rd_err  <= 1'b0;
    end else begin
      r_rd_err <= inc & w_full;
      // simultaneous grant and read return leave the count unchanged
      case ({w_inc_ok, w_dec_ok})
        2'b10:   r_credits <= r_credits + ONE;
        2'b01:   r_credits <= r_credits - ONE;
        default: r_credits <= r_credits;
      endcase
    end
  end

  assign credits = r_credits;
  assign zero    = w_zero;
  assign rd_err  = r_rd_err;

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Two-port round-robin write arbiter in front of one FIFO: at most one write
// every two cycles, never issuing a write without a free slot.
module fifo_wr_arbiter
  import fifo_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = fifo_pkg::DEPTH,
  parameter int CNT_W  = fifo_pkg::CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  fifo_wr_arbiter_if.slave  bus
);

  arb_state_t        r_state;
  arb_state_t        w_state_next;
  logic              r_rr;
  logic              w_rr_next;
  logic              w_grant0;
  logic              w_grant1;
  logic              w_grant;
  logic              w_any_req;
  logic              w_zero;
  logic              r_wr_en;
  logic              r_ack0;
  logic              r_ack1;
  logic              r_stall;
  logic [DATA_W-1:0] r_wr_data;
  logic [CNT_W-1:0]  w_credits;
  logic              w_rd_err;

  assign w_any_req = bus.req0 | bus.req1;
  assign w_grant   = w_grant0 | w_grant1;

  fifo_credit_cnt #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_credit_cnt (
    .clk     (clk),
    .reset   (reset),
    .flush   (flush),
    .dec     (w_grant),
    .inc     (bus.rd_done),
    .credits (w_credits),
    .zero    (w_zero),
    .rd_err  (w_rd_err)
  );

  always_comb begin
    w_state_next = r_state;
    w_rr_next    = r_rr;
    w_grant0     = 1'b0;
    w_grant1     = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_any_req) begin
          if (w_zero) begin
            w_state_next = STALL;
          end else if (bus.req0 && (!bus.req1 || !r_rr)) begin
            w_grant0     = 1'b1;
            w_state_next = GNT0;
            w_rr_next    = 1'b1;
          end else begin
            w_grant1     = 1'b1;
            w_state_next = GNT1;
            w_rr_next    = 1'b0;
          end
        end
      end
      // requests are ignored here so the acked producer's stale req cannot re-win
      GNT0, GNT1: w_state_next = IDLE;
      STALL: begin
        if (!w_zero || !w_any_req) begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      r_state   <= IDLE;
      r_rr      <= 1'b0;
      r_wr_en   <= 1'b0;
      r_ack0    <= 1'b0;
      r_ack1    <= 1'b0;
      r_stall   <= 1'b0;
      r_wr_data <= '0;
    end else begin
      r_state <= w_state_next;
      r_rr    <= w_rr_next;
      r_wr_en <= w_grant;
      r_ack0  <= w_grant0;
      r_ack1  <= w_grant1;
      r_stall <= (w_state_next == STALL);
      if (w_grant0) begin
        r_wr_data <= bus.din0;
      end else if (w_grant1) begin
        r_wr_data <= bus.din1;
      end
    end
  end

  assign bus.wr_en   = r_wr_en;
  assign bus.wr_data = r_wr_data;
  assign bus.ack0    = r_ack0;
  assign bus.ack1    = r_ack1;
  assign bus.stall   = r_stall;
  assign bus.credits = w_credits;
  assign bus.rd_err  = w_rd_err;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: directed scenarios plus randomized producers and
// consumer, compared every cycle against a behavioural model of the arbiter.
module tb_fifo_wr_arbiter;

  localparam int DW  = 32;
  localparam int DEP = 8;
  localparam int CW  = 4;

  logic clk = 1'b0;
  logic reset;
  logic flush;

  fifo_wr_arbiter_if #(.DATA_W(DW), .CNT_W(CW)) bus ();

  fifo_wr_arbiter #(.DATA_W(DW), .DEPTH(DEP), .CNT_W(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  // behavioural model: expected outputs after the coming edge
  int          m_cred  = DEP;
  bit          m_rr    = 1'b0;
  bit          m_wr    = 1'b0;
  bit          m_ack0  = 1'b0;
  bit          m_ack1  = 1'b0;
  bit          m_stall = 1'b0;
  bit          m_rderr = 1'b0;
  logic [31:0] m_data  = '0;

  task automatic model_step();
    bit r0, r1, rd, st;
    int g;
    r0 = bus.req0;
    r1 = bus.req1;
    rd = bus.rd_done;
    if (reset || flush) begin
      m_cred = DEP; m_rr = 1'b0; m_wr = 1'b0; m_ack0 = 1'b0; m_ack1 = 1'b0;
      m_stall = 1'b0; m_rderr = 1'b0; m_data = '0;
      return;
    end
    g  = -1;
    st = 1'b0;
    if (m_wr) begin
      g = -1;
    end else if (m_stall) begin
      st = (r0 || r1) && (m_cred == 0);
    end else if (r0 || r1) begin
      if (m_cred == 0)      st = 1'b1;
      else if (r0 && r1)    g  = int'(m_rr);
      else                  g  = r0 ? 0 : 1;
    end
    m_rderr = rd && (m_cred == DEP);
    m_cred  = m_cred + ((rd && m_cred < DEP) ? 1 : 0) - ((g >= 0) ? 1 : 0);
    m_wr    = (g >= 0);
    m_ack0  = (g == 0);
    m_ack1  = (g == 1);
    m_stall = st;
    if (g >= 0) begin
      m_data = (g == 0) ? bus.din0 : bus.din1;
      m_rr   = (g == 0);
    end
  endtask

  function automatic logic [8:0] dut_vec();
    return {bus.wr_en, bus.ack0, bus.ack1, bus.stall, bus.rd_err, bus.credits};
  endfunction

  function automatic logic [8:0] exp_vec();
    return {m_wr, m_ack0, m_ack1, m_stall, m_rderr, 4'(m_cred)};
  endfunction

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    cyc++;
    if (bus.wr_en === 1'b1)
      $display("cycle %0d: write port%0d data=%08h credits=%0d",
               cyc, bus.ack1 ? 1 : 0, bus.wr_data, bus.credits);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      vectors++;
      if (dut_vec() !== exp_vec() || bus.credits !== 4'd8 || bus.wr_en !== 1'b0 ||
          bus.ack0 !== 1'b0 || bus.ack1 !== 1'b0 || bus.stall !== 1'b0 || bus.wr_data !== 32'h0) begin
        miscompares++;
        $display("FAIL reset cyc=%0d got=%b data=%h want=%b data=0", cyc, dut_vec(), bus.wr_data, exp_vec());
      end
    end
  endtask

  task automatic test_single_write();
    bus.din0 = 32'hA5A5_0001;
    bus.req0 = 1'b1;
    tick();
    vectors++;
    if (dut_vec() !== exp_vec() || bus.wr_en !== 1'b1 || bus.ack0 !== 1'b1 ||
        bus.wr_data !== 32'hA5A5_0001 || bus.credits !== 4'd7) begin
      miscompares++;
      $display("FAIL single_write got=%b data=%h want=%b data=a5a50001", dut_vec(), bus.wr_data, exp_vec());
    end
    // req0 deliberately left high during the ack cycle
    for (int i = 0; i < 2; i++) begin
      tick();
      bus.req0 = 1'b0;
      vectors++;
      if (dut_vec() !== exp_vec() || bus.wr_en !== 1'b0 || bus.credits !== 4'd7) begin
        miscompares++;
        $display("FAIL stale_req cyc=%0d got=%b want=%b", cyc, dut_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_alternate();
    int exp_port, grants, last;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    bus.din0 = $urandom();
    bus.din1 = $urandom();
    bus.req0 = 1'b1;
    bus.req1 = 1'b1;
    exp_port = 0;
    grants   = 0;
    last     = 0;
    for (int i = 0; i < 16; i++) begin
      bus.rd_done = (m_cred < DEP);
      tick();
      vectors++;
      if (dut_vec() !== exp_vec() || (m_wr && bus.wr_data !== m_data)) begin
        miscompares++;
        $display("FAIL alternate cyc=%0d got=%b/%h want=%b/%h", cyc, dut_vec(), bus.wr_data, exp_vec(), m_data);
      end
      if (bus.wr_en === 1'b1) begin
        vectors++;
        if (int'(bus.ack1) != exp_port || (grants > 0 && cyc - last != 2)) begin
          miscompares++;
          $display("FAIL alt_order grant=%0d got port%0d gap=%0d want port%0d gap=2",
                   grants, bus.ack1, cyc - last, exp_port);
        end
        if (bus.ack0 === 1'b1) bus.din0 = $urandom();
        if (bus.ack1 === 1'b1) bus.din1 = $urandom();
        exp_port ^= 1;
        grants++;
        last = cyc;
      end
    end
    vectors++;
    if (grants != 8) begin
      miscompares++;
      $display("FAIL alt_count got %0d grants want 8", grants);
    end
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    bus.rd_done = 1'b0;
    tick();
  endtask

  task automatic test_stall();
    int acks, n;
    bit seen;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    bus.req1 = 1'b1;
    bus.din1 = $urandom();
    acks = 0;
    for (int i = 0; i < 40 && acks < 8; i++) begin
      tick();
      vectors++;
      if (dut_vec() !== exp_vec() || (m_wr && bus.wr_data !== m_data)) begin
        miscompares++;
        $display("FAIL stall_fill cyc=%0d got=%b/%h want=%b/%h", cyc, dut_vec(), bus.wr_data, exp_vec(), m_data);
      end
      if (bus.ack1 === 1'b1) begin
        acks++;
        bus.din1 = $urandom();
      end
    end
    vectors++;
    if (acks != 8 || bus.credits !== 4'd0) begin
      miscompares++;
      $display("FAIL stall_empty got acks=%0d credits=%0d want acks=8 credits=0", acks, bus.credits);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      vectors++;
      if (dut_vec() !== exp_vec() || bus.wr_en !== 1'b0) begin
        miscompares++;
        $display("FAIL stall_nowrite cyc=%0d got=%b want=%b", cyc, dut_vec(), exp_vec());
      end
    end
    vectors++;
    if (bus.stall !== 1'b1) begin
      miscompares++;
      $display("FAIL stall_flag got %b want 1", bus.stall);
    end
    bus.rd_done = 1'b1;
    tick();
    bus.rd_done = 1'b0;
    vectors++;
    if (dut_vec() !== exp_vec() || bus.credits !== 4'd1 || bus.wr_en !== 1'b0) begin
      miscompares++;
      $display("FAIL stall_credit got=%b want=%b", dut_vec(), exp_vec());
    end
    seen = 1'b0;
    n    = 0;
    for (int i = 1; i <= 5 && !seen; i++) begin
      tick();
      vectors++;
      if (dut_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL stall_release_cyc cyc=%0d got=%b want=%b", cyc, dut_vec(), exp_vec());
      end
      if (bus.wr_en === 1'b1) begin
        seen = 1'b1;
        n    = i;
      end
    end
    vectors++;
    if (!seen || n != 2 || bus.credits !== 4'd0) begin
      miscompares++;
      $display("FAIL stall_release got seen=%0d after=%0d credits=%0d want seen=1 after=2 credits=0",
               seen, n, bus.credits);
    end
    bus.req1 = 1'b0;
    tick();
  endtask

  task automatic test_same_cycle();
    int acks;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    bus.req0 = 1'b1;
    bus.din0 = $urandom();
    acks = 0;
    for (int i = 0; i < 20 && acks < 3; i++) begin
      tick();
      vectors++;
      if (dut_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL same_fill cyc=%0d got=%b want=%b", cyc, dut_vec(), exp_vec());
      end
      if (bus.ack0 === 1'b1) begin
        acks++;
        bus.din0 = $urandom();
      end
    end
    bus.req0 = 1'b0;
    tick();
    bus.req0    = 1'b1;
    bus.rd_done = 1'b1;
    tick();
    bus.req0    = 1'b0;
    bus.rd_done = 1'b0;
    vectors++;
    if (dut_vec() !== exp_vec() || bus.wr_en !== 1'b1 || bus.credits !== 4'd5) begin
      miscompares++;
      $display("FAIL same_cycle got=%b credits=%0d want=%b credits=5", dut_vec(), bus.credits, exp_vec());
    end
    tick();
    for (int i = 0; i < 4; i++) begin
      bus.rd_done = 1'b1;
      tick();
      vectors++;
      if (dut_vec() !== exp_vec() || bus.credits !== 4'((i < 3) ? 6 + i : 8) ||
          bus.rd_err !== ((i == 3) ? 1'b1 : 1'b0)) begin
        miscompares++;
        $display("FAIL rd_done_step%0d got credits=%0d rd_err=%b want credits=%0d rd_err=%0d",
                 i, bus.credits, bus.rd_err, (i < 3) ? 6 + i : 8, (i == 3) ? 1 : 0);
      end
    end
    bus.rd_done = 1'b0;
    tick();
    vectors++;
    if (dut_vec() !== exp_vec() || bus.rd_err !== 1'b0 || bus.credits !== 4'd8) begin
      miscompares++;
      $display("FAIL rd_err_pulse got=%b want=%b", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_flush_gnt1();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    bus.req1 = 1'b1;
    bus.din1 = $urandom();
    tick();
    vectors++;
    if (dut_vec() !== exp_vec() || bus.ack1 !== 1'b1) begin
      miscompares++;
      $display("FAIL flush_setup got=%b want=%b", dut_vec(), exp_vec());
    end
    flush    = 1'b1;
    bus.req1 = 1'b0;
    tick();
    flush = 1'b0;
    vectors++;
    if (dut_vec() !== exp_vec() || bus.wr_en !== 1'b0 || bus.credits !== 4'd8 || bus.ack1 !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_gnt1 got=%b want=%b", dut_vec(), exp_vec());
    end
    bus.req0 = 1'b1;
    bus.req1 = 1'b1;
    bus.din0 = $urandom();
    tick();
    bus.req0 = 1'b0;
    vectors++;
    if (dut_vec() !== exp_vec() || bus.ack0 !== 1'b1) begin
      miscompares++;
      $display("FAIL flush_rr got ack0=%b ack1=%b want ack0=1 ack1=0", bus.ack0, bus.ack1);
    end
    tick();
    tick();
    bus.req1 = 1'b0;
    vectors++;
    if (dut_vec() !== exp_vec() || bus.ack1 !== 1'b1) begin
      miscompares++;
      $display("FAIL flush_next got=%b want=%b", dut_vec(), exp_vec());
    end
    tick();
    bus.req0 = 1'b1;
    bus.din0 = $urandom();
    flush    = 1'b1;
    tick();
    flush = 1'b0;
    vectors++;
    if (dut_vec() !== exp_vec() || bus.wr_en !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_cancel got=%b want=%b", dut_vec(), exp_vec());
    end
    tick();
    bus.req0 = 1'b0;
    vectors++;
    if (dut_vec() !== exp_vec() || bus.ack0 !== 1'b1 || bus.wr_data !== m_data) begin
      miscompares++;
      $display("FAIL flush_after got=%b/%h want=%b/%h", dut_vec(), bus.wr_data, exp_vec(), m_data);
    end
    tick();
  endtask

  task automatic test_random();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (!bus.req0 && $urandom_range(0, 2) == 0) begin
        bus.req0 = 1'b1;
        bus.din0 = $urandom();
      end
      if (!bus.req1 && $urandom_range(0, 2) == 0) begin
        bus.req1 = 1'b1;
        bus.din1 = $urandom();
      end
      bus.rd_done = ($urandom_range(0, 2) == 0);
      flush       = ($urandom_range(0, 63) == 0);
      tick();
      vectors++;
      if (dut_vec() !== exp_vec() || (m_wr && bus.wr_data !== m_data)) begin
        miscompares++;
        $display("FAIL random cyc=%0d got=%b/%h want=%b/%h", cyc, dut_vec(), bus.wr_data, exp_vec(), m_data);
      end
      if (bus.ack0 === 1'b1) begin
        bus.req0 = $urandom_range(0, 1);
        bus.din0 = $urandom();
      end
      if (bus.ack1 === 1'b1) begin
        bus.req1 = $urandom_range(0, 1);
        bus.din1 = $urandom();
      end
    end
    flush       = 1'b0;
    bus.req0    = 1'b0;
    bus.req1    = 1'b0;
    bus.rd_done = 1'b0;
    tick();
  endtask

  initial begin
    reset       = 1'b1;
    flush       = 1'b0;
    bus.req0    = 1'b0;
    bus.req1    = 1'b0;
    bus.din0    = '0;
    bus.din1    = '0;
    bus.rd_done = 1'b0;
    test_reset();
    test_single_write();
    test_alternate();
    test_stall();
    test_same_cycle();
    test_flush_gnt1();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d, want completion", cyc);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
Round-robin write arbiter that shares one 8-entry FIFO between two producer ports.
- Grants at most one write per two cycles.
- Drives the FIFO write strobe and data.
- Keeps a credit counter (free slots) so the FIFO is never written when full, so WR_ERROR is never provoked.
- Sits directly in front of the FIFO write side. The consumer reports completed reads back via rd_done.

Parameters:
- DATA_W, 32, width of producer data and FIFO write data.
- DEPTH, 8, FIFO capacity; initial and maximum credit value.
- CNT_W, 4, credit counter width; must hold 0..DEPTH.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- flush  input  1  synchronous clear; pulse together with the FIFO INIT
- req0  input  1  producer 0 write request; held until ack0
- din0  input  DATA_W  producer 0 data; stable while req0 is high
- ack0  output  1  one-cycle pulse: din0 has been written
- req1  input  1  producer 1 write request
- din1  input  DATA_W  producer 1 data
- ack1  output  1  one-cycle pulse: din1 has been written
- rd_done  input  1  one-cycle pulse per completed FIFO read
- wr_en  output  1  FIFO write enable
- wr_data  output  DATA_W  FIFO write data
- credits  output  CNT_W  free FIFO slots, 0..DEPTH
- stall  output  1  high while a request is pending and credits==0
- rd_err  output  1  one-cycle pulse: rd_done received while credits==DEPTH

Behaviour:
- Clocking and outputs:
  - All outputs are registered.
  - Single clock. Reset and flush are both synchronous; reset has highest priority, flush next.
- Reset and flush values:
  - state=IDLE, credits=DEPTH, rr_ptr=0.
  - wr_en, ack0, ack1, stall and rd_err are all 0; wr_data=0.
  - A flush or reset mid-grant cancels the grant. A write already strobed is not retracted.
- States: IDLE, GNT0, GNT1, STALL (encoding is in the package).
- IDLE, evaluated at each edge:
  - If no request: stay in IDLE.
  - If any request and credits==0: go to STALL.
  - If only one request: grant it.
  - If both requests: grant the port selected by rr_ptr.
- Grant to port n:
  - Next cycle: state=GNTn, wr_en=1, wr_data=din_n, ack_n=1.
  - rr_ptr becomes the other port; credits decrement.
- GNT0/GNT1:
  - Unconditionally return to IDLE and deassert wr_en/ack.
  - Requests are not sampled in this cycle, so stale req from the acked producer is ignored.
  - Result: latency from req to wr_en is 1 cycle; throughput is 1 write per 2 cycles.
- STALL:
  - stall=1.
  - Leave for IDLE when credits>0 or when no request is pending.
  - No write is ever issued while credits==0.
- Credit arithmetic, per cycle:
  - credits += rd_done_valid − grant.
  - A grant and rd_done in the same cycle leave credits unchanged.
  - rd_done at credits==DEPTH is ignored: credits hold and rd_err pulses.
  - Credits never underflow, because a grant requires credits>0 at the sample edge.
- Round robin:
  - rr_ptr toggles only on a grant.
  - A sole requester is granted regardless of rr_ptr.
- Producer rule: deassert req, or present new data, on the cycle after ack.

Decomposition:
- Shared package fifo_pkg holds:
  - the state encoding (IDLE, GNT0, GNT1, STALL);
  - the DEPTH=8 and CNT_W=4 constants;
  - the FIFO state encodings INIT..RD_ERROR, for use by other FIFO blocks.
- One sub-module, fifo_credit_cnt:
  - inputs: clk, reset, flush, dec, inc;
  - outputs: credits, zero, rd_err;
  - implements the saturating up/down counter.

Test Plan:
- Reset, then idle 5 cycles -> credits=8; wr_en, ack0, ack1, stall all 0.
- req0=1, din0=0xA5A5_0001, held until ack -> wr_en and ack0 high exactly 1 cycle after the sampling edge; wr_data=0xA5A5_0001; credits=7; no second write from the stale req.
- req0 and req1 both held continuously, rd_done tied so credits stay >0 -> grants alternate 0,1,0,1 with 2-cycle spacing.
- 8 writes from req1 with no rd_done -> credits=0; 9th request drives stall=1 with no wr_en; one rd_done pulse -> exactly 2 cycles later wr_en=1 and credits return to 0.
- Grant and rd_done in the same cycle at credits=5 -> credits remain 5; rd_done at credits=8 -> rd_err pulses, credits stay 8.
- flush asserted during GNT1 -> next cycle state=IDLE, credits=8, rr_ptr=0, wr_en=0.
